// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and its add/sub datapath.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_e;

  // Width of the iteration counter; never less than one bit.
  function automatic int unsigned count_width(int unsigned width);
    return ($clog2(width) > 0) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor: s = a + b when k=0, s = a - b when k=1.
module addsub_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] bx;

  always_comb begin
    bx   = b ^ {N{k}};
    c    = '0;
    s    = '0;
    c[0] = k;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider with start/done handshake.
// One trial subtraction per clock; divide-by-zero short-circuits to a flagged result.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = count_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             dbz_pend_q, dbz_pend_d;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic             sub_cout;
  logic             neg;

  // Partial remainder always fits in WIDTH bits since it stays below the divisor.
  assign rs  = {r_q, q_q[WIDTH-1]};
  assign neg = diff[WIDTH];

  addsub_n #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a    (rs),
    .b    ({1'b0, d_q}),
    .k    (1'b1),
    .s    (diff),
    .cout (sub_cout)
  );

  // With rs < 2*D the sign bit and the borrow-out must always agree.
  assert property (@(posedge clk) disable iff (rst)
                   (state_q == StRun) |-> (sub_cout != diff[WIDTH]));

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    dbz_pend_d  = dbz_pend_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d = dividend;
          if (divisor == '0) begin
            dbz_pend_d = 1'b1;
            state_d    = StDone;
          end else begin
            d_d     = divisor;
            r_d     = '0;
            count_d = CntW'(WIDTH - 1);
            busy_d  = 1'b1;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        r_d     = neg ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ~neg};
        count_d = count_q - CntW'(1);
        if (count_q == '0) begin
          state_d     = StDone;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = q_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
        end
      end

      StDone: begin
        state_d    = StIdle;
        dbz_pend_d = 1'b0;
        // Divide-by-zero publishes its result one edge after acceptance.
        if (dbz_pend_q) begin
          done_d      = 1'b1;
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      dbz_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      dbz_pend_q  <= dbz_pend_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=4.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors    = 0;
  int checks    = 0;
  int ops       = 0;
  int done_seen = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && done === 1'b1) done_seen++;

  // Called at a negedge; returns at a negedge one cycle after the done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (done === 1'b1) ops++;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout %0d/%0d: done=%b after %0d cycles, required 1", a, b, done, lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse %0d/%0d: done=%b one cycle later, required 0", a, b, done);
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b, required 000", {busy, done, div_by_zero});
    end
    checks++;
    if (quotient !== 4'd0 || remainder !== 4'd0) begin
      errors++;
      $display("FAIL reset_results: q=%0d r=%0d, required 0 0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt;
    run_op(4'd13, 4'd3, q, r, z, lat, bcnt);
    checks++;
    if (lat !== 4 || bcnt !== 4) begin
      errors++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, required 4 4", lat, bcnt);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL basic_13_3: q=%0d r=%0d dbz=%b, required 4 1 0", q, r, z);
    end
  endtask

  task automatic test_boundary;
    logic [W-1:0] vec_a [4] = '{4'd15, 4'd5, 4'd0, 4'd15};
    logic [W-1:0] vec_b [4] = '{4'd1,  4'd7, 4'd9, 4'd15};
    logic [W-1:0] exp_q [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [W-1:0] exp_r [4] = '{4'd0,  4'd5, 4'd0, 4'd0};
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      run_op(vec_a[i], vec_b[i], q, r, z, lat, bcnt);
      checks++;
      if (q !== exp_q[i] || r !== exp_r[i] || z !== 1'b0 || lat !== 4) begin
        errors++;
        $display("FAIL boundary_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d 0 4",
                 vec_a[i], vec_b[i], q, r, z, lat, exp_q[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt;
    run_op(4'd9, 4'd0, q, r, z, lat, bcnt);
    checks++;
    if (lat !== 1 || bcnt !== 0) begin
      errors++;
      $display("FAIL dbz_timing: latency=%0d busy_cycles=%0d, required 1 0", lat, bcnt);
    end
    checks++;
    if (q !== 4'd15 || r !== 4'd9 || z !== 1'b1) begin
      errors++;
      $display("FAIL dbz_9_0: q=%0d r=%0d dbz=%b, required 15 9 1", q, r, z);
    end
    run_op(4'd8, 4'd2, q, r, z, lat, bcnt);
    checks++;
    if (q !== 4'd4 || r !== 4'd0 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_dbz_8_2: q=%0d r=%0d dbz=%b, required 4 0 0", q, r, z);
    end
  endtask

  task automatic test_ignored_start;
    int bad;
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    if (done === 1'b1) ops++;
    checks++;
    if (done !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_12_5: done=%b q=%0d r=%0d dbz=%b, required 1 2 2 0",
               done, quotient, remainder, div_by_zero);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd2 || remainder !== 4'd2) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_hold: %0d cycles deviated from idle q=2 r=2, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt, bad;
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL run_hold: busy=%b q=%0d r=%0d, required 1 2 2", busy, quotient, remainder);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 4'd0 || remainder !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: busy/done/dbz=%b q=%0d r=%0d, required 000 0 0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d cycles with done/busy after reset, required 0", bad);
    end
    run_op(4'd14, 4'd4, q, r, z, lat, bcnt);
    checks++;
    if (q !== 4'd3 || r !== 4'd2 || z !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_14_4: q=%0d r=%0d dbz=%b, required 3 2 0", q, r, z);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt;
    bit           ok;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), q, r, z, lat, bcnt);
        if (b == 0) ok = (int'(q) == 15) && (int'(r) == a) && (z === 1'b1) && (lat == 1);
        else ok = (int'(q) * b + int'(r) == a) && (int'(r) < b) && (z === 1'b0) && (lat == 4);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d, invariant violated",
                   a, b, q, r, z, lat);
        end
      end
    end
    checks++;
    if (done_seen != ops) begin
      errors++;
      $display("FAIL done_count: %0d done cycles seen, required %0d", done_seen, ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
